// File: rtl/para7_pkg.sv
// ============================================================================
//  Module      : para7_pkg
//  Description : Shared types and constants for the layer-7 parameter streamer.
//                Word width, mode/valid encodings, segment indices, FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package para7_pkg;

    // Word format and handshake encodings seen by the layer-7 loader
    localparam int   PARA_WIDTH = 16;
    localparam logic LOAD_PARA  = 1'b1;
    localparam logic CALCULATE  = 1'b0;
    localparam logic DATAVALID  = 1'b1;

    // Default image geometry
    localparam int DEF_FM_DEPTH    = 256;
    localparam int DEF_CHANNEL_NUM = 512;
    localparam int TOTAL           = DEF_FM_DEPTH + 5 * DEF_CHANNEL_NUM;

    // Segment index carried alongside every word
    typedef logic [2:0] seg_t;
    localparam seg_t SEG_RSIGN = 3'd0;
    localparam seg_t SEG_BN_A  = 3'd1;
    localparam seg_t SEG_BN_B  = 3'd2;
    localparam seg_t SEG_BETA  = 3'd3;
    localparam seg_t SEG_GAMMA = 3'd4;
    localparam seg_t SEG_ZETA  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/para_skid_buf.sv
// ============================================================================
//  Module      : para_skid_buf
//  Description : Two-entry FIFO absorbing the in-flight SRAM read while the
//                downstream loader holds. Caller never pushes when full or
//                pops when empty.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module para_skid_buf #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Storage needs no reset: an entry is only read after it was written
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) r_wr_ptr <= ~r_wr_ptr;
            if (pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/para_streamer_layer7.sv
// ============================================================================
//  Module      : para_streamer_layer7
//  Description : Reads the layer-7 parameter image from a synchronous SRAM and
//                streams it word by word (mode / data-enable / word / segment)
//                into the layer-7 parameter loader, honouring a downstream hold.
//                Optional feature macro: PARA_STREAM_CHECKSUM_EN (reads one
//                extra checksum word and flags a sum mismatch at done).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module para_streamer_layer7
    import para7_pkg::*;
#(
    parameter int FM_DEPTH    = DEF_FM_DEPTH,
    parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [PARA_WIDTH-1:0] rd_data,
    output logic                  mode_o,
    output logic                  data_e_para,
    output logic [PARA_WIDTH-1:0] para_out,
    output logic [2:0]            seg_o,
    output logic                  busy,
    output logic                  done,
    output logic                  checksum_err
);

    localparam int c_TOTAL = FM_DEPTH + 5 * CHANNEL_NUM;
`ifdef PARA_STREAM_CHECKSUM_EN
    localparam int c_LIMIT = c_TOTAL + 1;
`else
    localparam int c_LIMIT = c_TOTAL;
`endif
    localparam int                    c_EW        = PARA_WIDTH + 3;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(c_LIMIT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_FM_LAST   = ADDR_WIDTH'(FM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_CH_LAST   = ADDR_WIDTH'(CHANNEL_NUM - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_off;
    seg_t                  r_seg;
    logic                  r_rd_vld;
    seg_t                  r_rd_seg;
    logic                  r_out_vld;
    logic [PARA_WIDTH-1:0] r_out_data;
    seg_t                  r_out_seg;

    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_arr;
    logic                  w_out_load;
    logic                  w_buf_nempty;
    logic                  w_src_vld;
    logic [c_EW-1:0]       w_src;
    logic                  w_push;
    logic                  w_pop;
    logic [c_EW-1:0]       w_buf_dout;
    logic [1:0]            w_buf_cnt;
    logic                  w_drained;

    // Reads are issued only on non-held cycles, so at most one word is ever in flight
    assign w_issue      = (r_state == READ) && !hold;
    assign w_last_issue = w_issue && (r_addr == c_LAST_ADDR);

`ifdef PARA_STREAM_CHECKSUM_EN
    logic                  r_rd_chk;
    logic [PARA_WIDTH-1:0] r_sum;
    logic [PARA_WIDTH-1:0] r_expect;
    logic                  r_chk_err;
    logic                  w_consume;
    logic [PARA_WIDTH-1:0] w_sum_next;
    logic [PARA_WIDTH-1:0] w_expect;

    // The checksum word rides the read pipe but is never emitted
    assign w_arr      = r_rd_vld && !r_rd_chk;
    assign w_consume  = r_out_vld && !hold;
    assign w_sum_next = r_sum + (w_consume ? r_out_data : '0);
    assign w_expect   = (r_rd_vld && r_rd_chk) ? rd_data : r_expect;

    // Running sum of emitted words, compared against the stored checksum on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_chk  <= 1'b0;
            r_sum     <= '0;
            r_expect  <= '0;
            r_chk_err <= 1'b0;
        end else begin
            r_rd_chk <= w_issue && (r_addr == ADDR_WIDTH'(c_TOTAL));
            if (r_rd_vld && r_rd_chk) r_expect <= rd_data;
            if (r_state == IDLE && start) begin
                r_sum     <= '0;
                r_chk_err <= 1'b0;
            end else begin
                r_sum <= w_sum_next;
                if (r_state == DRAIN && w_drained) r_chk_err <= (w_sum_next != w_expect);
            end
        end
    end

    assign checksum_err = r_chk_err;
`else
    assign w_arr        = r_rd_vld;
    assign checksum_err = 1'b0;
`endif

    // Issue side: linear address plus segment/offset counters (no divider needed)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_off    <= '0;
            r_seg    <= SEG_RSIGN;
            r_rd_vld <= 1'b0;
            r_rd_seg <= SEG_RSIGN;
        end else begin
            r_rd_vld <= w_issue;
            r_rd_seg <= r_seg;
            if (w_last_issue) begin
                r_addr <= '0;
                r_off  <= '0;
                r_seg  <= SEG_RSIGN;
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                if ((r_seg == SEG_RSIGN && r_off == c_FM_LAST) ||
                    (r_seg != SEG_RSIGN && r_off == c_CH_LAST)) begin
                    r_seg <= r_seg + 3'd1;
                    r_off <= '0;
                end else begin
                    r_off <= r_off + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Output register refills from the skid buffer first, else straight from the SRAM
    assign w_out_load   = !r_out_vld || !hold;
    assign w_buf_nempty = (w_buf_cnt != 2'd0);
    assign w_src_vld    = w_buf_nempty || w_arr;
    assign w_src        = w_buf_nempty ? w_buf_dout : {r_rd_seg, rd_data};
    assign w_pop        = w_out_load && w_buf_nempty;
    assign w_push       = w_arr && (w_buf_nempty || !w_out_load);
    assign w_drained    = w_out_load && !w_src_vld;

    para_skid_buf #(
        .WIDTH (c_EW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({r_rd_seg, rd_data}),
        .pop       (w_pop),
        .pop_data  (w_buf_dout),
        .count     (w_buf_cnt)
    );

    // Presented word; data and segment keep their last value when nothing new loads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_seg  <= SEG_RSIGN;
        end else if (w_out_load) begin
            r_out_vld <= w_src_vld;
            if (w_src_vld) {r_out_seg, r_out_data} <= w_src;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = READ;
            READ:    if (w_last_issue) w_state_next = DRAIN;
            DRAIN:   if (w_drained) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = (r_state == READ) || (r_state == DRAIN);
        done   = (r_state == DONE);
        mode_o = busy ? LOAD_PARA : CALCULATE;
    end

    assign rd_en       = w_issue;
    assign rd_addr     = r_addr;
    assign data_e_para = (r_out_vld && !hold) ? DATAVALID : ~DATAVALID;
    assign para_out    = r_out_data;
    assign seg_o       = r_out_seg;

endmodule

`default_nettype wire

// File: tb/tb_para_streamer_layer7.sv
// ============================================================================
//  Module      : tb_para_streamer_layer7
//  Description : Self-checking bench for para_streamer_layer7 with an SRAM
//                model and an index-based reference of the emitted stream.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_para_streamer_layer7;
    import para7_pkg::*;

    localparam int c_FM     = 256;
    localparam int c_CH     = 512;
    localparam int c_AW     = 12;
    localparam int c_TOTAL  = c_FM + 5 * c_CH;
`ifdef PARA_STREAM_CHECKSUM_EN
    localparam int c_LIMIT  = c_TOTAL + 1;
`else
    localparam int c_LIMIT  = c_TOTAL;
`endif
    localparam int c_BUDGET = 4 * c_TOTAL;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  hold;
    logic                  rd_en;
    logic [c_AW-1:0]       rd_addr;
    logic [PARA_WIDTH-1:0] rd_data;
    logic                  mode_o;
    logic                  data_e_para;
    logic [PARA_WIDTH-1:0] para_out;
    logic [2:0]            seg_o;
    logic                  busy;
    logic                  done;
    logic                  checksum_err;

    para_streamer_layer7 #(
        .FM_DEPTH    (c_FM),
        .CHANNEL_NUM (c_CH),
        .ADDR_WIDTH  (c_AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hold         (hold),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .mode_o       (mode_o),
        .data_e_para  (data_e_para),
        .para_out     (para_out),
        .seg_o        (seg_o),
        .busy         (busy),
        .done         (done),
        .checksum_err (checksum_err)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: data valid the cycle after rd_en
    logic [PARA_WIDTH-1:0] mem [0:4095];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    endtask

    // Reference: segment of stream index idx
    function automatic int exp_seg(input int idx);
        return (idx < c_FM) ? 0 : 1 + (idx - c_FM) / c_CH;
    endfunction

    // Stream observer state
    int   exp_idx, nwords, done_cnt, first_de, done_at;
    logic err_at_done;

    initial begin
        exp_idx = 0; nwords = 0; done_cnt = 0; first_de = -1; done_at = -1; err_at_done = 1'b0;
        forever begin
            @(negedge clk);
            if (hold) check("held_de", data_e_para, 1'b0);
            if (rd_en) check("rd_addr_range", rd_addr < c_LIMIT, 1'b1);
            if (data_e_para) begin
                if (nwords == 0) first_de = cyc + 1;
                if (exp_idx < c_TOTAL) begin
                    check("word", para_out, mem[exp_idx]);
                    check("seg", seg_o, exp_seg(exp_idx));
                end
                exp_idx++;
                nwords++;
            end
            if (done) begin
                done_cnt++;
                done_at     = cyc + 1;
                err_at_done = checksum_err;
            end
        end
    end

    // hmode: 0 no hold, 1 fixed hold pattern, 2 random hold, 3 no hold + stray starts
    task automatic run_stream(input int hmode, input int rst_word, output int k, output bit aborted);
        int rel;
        exp_idx = 0; nwords = 0; done_cnt = 0; first_de = -1; done_at = -1;
        aborted = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = cyc;
        for (int t = 0; t < c_BUDGET; t++) begin
            if (rst_word >= 0 && nwords >= rst_word) begin
                aborted = 1'b1;
                break;
            end
            if (done_cnt != 0) break;
            rel = cyc + 1 - k;
            case (hmode)
                1:       hold = (rel >= 10 && rel <= 14) || (rel >= 100 && rel <= 200 && rel % 2 == 0);
                2:       hold = ($urandom_range(0, 3) == 0);
                default: hold = 1'b0;
            endcase
            start = (hmode == 3) && (rel == 50 || rel == 2000);
            @(posedge clk); #1;
        end
        hold  = 1'b0;
        start = 1'b0;
        if (!aborted && done_cnt == 0) check("done_timeout", done_cnt, 1);
    endtask

    task automatic settle_and_count();
        repeat (6) @(posedge clk);
        #1;
        check("done_count", done_cnt, 1);
        check("word_count", nwords, c_TOTAL);
`ifndef PARA_STREAM_CHECKSUM_EN
        check("chk_err_tied", err_at_done, 1'b0);
`endif
    endtask

    initial begin
        int   k;
        bit   ab;
        logic [PARA_WIDTH-1:0] sum;
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   k;
        bit   ab;
        logic [PARA_WIDTH-1:0] sum;
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = PARA_WIDTH'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_de", data_e_para, 1'b0);
        check("rst_para_out", para_out, 0);
        check("rst_seg", seg_o, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_chk_err", checksum_err, 1'b0);
        check("rst_mode", mode_o, CALCULATE);

        // start coincident with rst is lost
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("rst_wins_busy", busy, 1'b0);
        check("rst_wins_rd_en", rd_en, 1'b0);

        // Linear image, no hold: exact latency
        run_stream(0, -1, k, ab);
        check("first_de_cycle", first_de, k + 3);
        check("done_cycle", done_at, k + 3 + c_TOTAL);
        settle_and_count();

        // Random image, fixed hold pattern
        for (int i = 0; i < 4096; i++) mem[i] = PARA_WIDTH'($urandom);
        run_stream(1, -1, k, ab);
        settle_and_count();

        // Stray start pulses while busy are ignored
        run_stream(3, -1, k, ab);
        check("stray_done_cycle", done_at, k + 3 + c_TOTAL);
        settle_and_count();

        // Random hold, reset at word 1000, then full restart from word 0
        run_stream(2, 1000, k, ab);
        check("abort_taken", ab, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_mode", mode_o, CALCULATE);
        check("abort_de", data_e_para, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rd_en", rd_en, 1'b0);
        @(posedge clk); #1;
        run_stream(0, -1, k, ab);
        check("restart_first_de", first_de, k + 3);
        settle_and_count();

        // Back-to-back: start in the first IDLE cycle after DONE
        run_stream(2, -1, k, ab);
        check("b2b_first_words", nwords, c_TOTAL);
        check("b2b_first_done", done_cnt, 1);
        run_stream(0, -1, k, ab);
        check("b2b_first_de", first_de, k + 3);
        check("b2b_done_cycle", done_at, k + 3 + c_TOTAL);
        settle_and_count();

`ifdef PARA_STREAM_CHECKSUM_EN
        for (int i = 0; i < 4096; i++) mem[i] = PARA_WIDTH'(i);
        sum = '0;
        for (int i = 0; i < c_TOTAL; i++) sum = sum + PARA_WIDTH'(i);
        mem[c_TOTAL] = sum + PARA_WIDTH'(1);
        run_stream(2, -1, k, ab);
        check("chk_bad_at_done", err_at_done, 1'b1);
        settle_and_count();
        check("chk_bad_held", checksum_err, 1'b1);
        mem[c_TOTAL] = sum;
        run_stream(0, -1, k, ab);
        check("chk_good_at_done", err_at_done, 1'b0);
        settle_and_count();
        check("chk_good_held", checksum_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
